io_responder_m: RTL and testbench
=================================

# io_responder_m

Responder for the CPU I/O window at 0x7000–0x7003, driven by the select lines from the address decoder. It holds the vblank flag and vblank IRQ latch. Once per frame it polls two NES-style serial controllers and returns their button bytes on the CPU data bus. Read data is combinational from internal registers; all state changes are synchronous to `clk`.

## Interface
Parameters:
- `CLK_DIV`, default 8: length of each controller latch/clock phase in `clk` cycles. Legal range is ≥1.

Ports:
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: synchronous, active-high reset.
- `cpu_access` in 1: one-cycle strobe marking a valid CPU bus cycle.
- `cpu_rwb` in 1: 1 = read, 0 = write.
- `SELECT_in_vblank`, `SELECT_clr_vblank_irq`, `SELECT_controller_1`, `SELECT_controller_2` in 1 each: decoded selects. At most one is high at a time.
- `cpu_data_out` out 8: read data.
- `cpu_data_oe` out 1: high when this block drives the data bus.
- `vblank` in 1: level from video timing.
- `vblank_start` in 1: one-cycle pulse on the first cycle of vblank.
- `vblank_irq` out 1: active-high interrupt request.
- `ctrl_latch` out 1: shared controller latch.
- `ctrl_clk` out 1: shared controller shift clock.
- `ctrl_data_1`, `ctrl_data_2` in 1 each: serial data, active-low (0 = pressed). Both inputs are synchronised externally.

## Operation
- **Reset values:** `vblank_irq`=0, `ctrl_latch`=0, `ctrl_clk`=0, both controller registers=0x00, FSM=IDLE, `cpu_data_oe`=0.
- **Read mux:** `cpu_data_oe` = `cpu_rwb` & (any select). Otherwise `cpu_data_out` = 0x00.
  - `in_vblank` reads `{7'b0, vblank}`.
  - `clr_vblank_irq` reads `{7'b0, vblank_irq}`.
  - `controller_1` / `controller_2` read their committed registers.
- **IRQ latch:**
  - Set on `vblank_start`.
  - Cleared by `cpu_access` & `SELECT_clr_vblank_irq`, for either a read or a write.
  - If set and clear occur in the same cycle, set wins.
- **Button byte layout:** bits 7..0 = A, B, Select, Start, Up, Down, Left, Right. A stored 1 means pressed, so the serial data is inverted on capture.
- **Poll FSM states:** IDLE → LATCH → LOW → HIGH → (LOW … ) → COMMIT → IDLE.
  - IDLE: waits for `vblank_start`.
  - LATCH: `ctrl_latch`=1 for `CLK_DIV` cycles.
  - LOW: `ctrl_clk`=0 for `CLK_DIV` cycles. On the last LOW cycle, both data pins are sampled and shifted left into per-controller shift registers, with the new bit inserted at bit 0.
  - HIGH: `ctrl_clk`=1 for `CLK_DIV` cycles.
  - The LOW/HIGH pair repeats 8 times, tracked by a 3-bit bit counter that wraps 7→0 on exit.
  - COMMIT: one cycle that copies both shift registers into the visible registers at the same edge.
- **Coherency:** a CPU read never sees a partially shifted byte. The visible registers change only in COMMIT.
- `vblank_start` while the FSM is not in IDLE is ignored by the FSM. It still sets the IRQ.
- Writes to the `in_vblank` or controller addresses are ignored.
- **Reset mid-poll:** the FSM returns to IDLE and the outputs return to their reset values. The shift registers and visible registers clear, and no partial commit occurs.

## Timing
- Reads have zero latency: combinational from registers.
- A CPU read in the COMMIT cycle returns the old value. A read in the cycle after returns the new value.
- Counting from the cycle when `vblank_start` is high as cycle 0:
  - `ctrl_latch` is high on cycles 1..`CLK_DIV`.
  - Bit i is sampled on cycle `CLK_DIV`·(2i+2).
  - COMMIT is cycle 17·`CLK_DIV`+1.
  - New values are visible from cycle 17·`CLK_DIV`+2. With the default, that is cycle 138.
- `vblank_irq` rises the cycle after `vblank_start` and falls the cycle after the clearing access.
- The phase counter width is clog2(`CLK_DIV`+1). It reloads on every state entry.

## Structure
- **Shared package or include `io_pkg`:**
  - FSM state encodings: IDLE, LATCH, LOW, HIGH, COMMIT.
  - Button bit-index constants.
  - I/O address constants 0x7000–0x7003, shared with the decoder.
- **Sub-module `controller_poller_m`:** owns the FSM, phase and bit counters, shift registers, and committed registers. It takes `clk`, `rst`, `vblank_start`, and the data pins, and outputs `ctrl_latch`, `ctrl_clk`, and two bytes.
- **Top level:** the top holds the IRQ latch and the read mux.

## Test plan
- **Reset:** assert `rst` for 2 cycles during the HIGH phase of bit 3 → all outputs are 0, both controller reads return 0x00, and the next `vblank_start` starts a clean poll.
- **IRQ set and clear:** pulse `vblank_start` → `vblank_irq`=1. A read at 0x7001 returns 0x01 and clears it. A simultaneous `vblank_start` with a clear access leaves `vblank_irq`=1.
- **Poll with default `CLK_DIV`=8:** controller 1 model sends A and Right pressed; controller 2 sends Start pressed. Expect 0x81 and 0x10 at 0x7002 / 0x7003 from cycle 138, and 0x00 at cycle 137.
- **Retrigger:** a `vblank_start` pulse at cycle 50 of an active poll → latch and clock waveform unchanged, one commit only, IRQ set.
- **`CLK_DIV`=1:** `ctrl_latch` lasts 1 cycle, 16 alternating clock phases follow, and COMMIT occurs at cycle 18. Controller data 0x00 on the wire gives 0xFF pressed.
- **Bus:** a write to 0x7002 leaves the register unchanged and `cpu_data_oe`=0. A read of 0x7000 during vblank returns 0x01 with `cpu_data_oe`=1.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: definitions shared by the CPU I/O responder and the address decoder.
//   - poll_state_t : controller poll FSM states
//   - BTN_*        : bit positions inside a committed button byte (1 = pressed)
//   - IO_ADDR_*    : CPU addresses of the I/O window 0x7000-0x7003
//   - flag_byte()  : widens a single status flag to a read-data byte
package io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_COMMIT = 3'd4
  } poll_state_t;

  localparam int unsigned BTN_A      = 7;
  localparam int unsigned BTN_B      = 6;
  localparam int unsigned BTN_SELECT = 5;
  localparam int unsigned BTN_START  = 4;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_RIGHT  = 0;

  localparam logic [15:0] IO_ADDR_IN_VBLANK      = 16'h7000;
  localparam logic [15:0] IO_ADDR_CLR_VBLANK_IRQ = 16'h7001;
  localparam logic [15:0] IO_ADDR_CONTROLLER_1   = 16'h7002;
  localparam logic [15:0] IO_ADDR_CONTROLLER_2   = 16'h7003;

  function automatic logic [7:0] flag_byte(input logic flag);
    return {7'b0, flag};
  endfunction

endpackage

// File: rtl/controller_poller_m.sv
// controller_poller_m: polls two NES-style serial controllers once per frame.
// On vblank_start (while idle) it pulses ctrl_latch for CLK_DIV cycles, then
// runs 8 LOW/HIGH ctrl_clk phases of CLK_DIV cycles each, sampling both data
// pins on the last LOW cycle of every bit, and finally copies both shift
// registers into the visible button bytes in a single COMMIT cycle.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   vblank_start           : one-cycle frame-start pulse
//   ctrl_data_1/2          : serial data, active-low (0 = pressed)
//   ctrl_latch, ctrl_clk   : shared controller latch / shift clock (registered)
//   buttons_1, buttons_2   : committed button bytes, 1 = pressed, A at bit 7
module controller_poller_m
  import io_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblank_start,
  input  logic       ctrl_data_1,
  input  logic       ctrl_data_2,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic [7:0] buttons_1,
  output logic [7:0] buttons_2
);

  localparam int unsigned PW = $clog2(CLK_DIV + 1);
  // Phase counter counts down to zero; loaded on every state entry so each
  // state lasts exactly CLK_DIV cycles.
  localparam logic [PW-1:0] PHASE_LOAD = PW'(CLK_DIV - 1);

  poll_state_t   state;
  logic [PW-1:0] phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_1;
  logic [7:0]    shift_2;
  logic          phase_done;

  assign phase_done = (phase == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      shift_1    <= '0;
      shift_2    <= '0;
      buttons_1  <= '0;
      buttons_2  <= '0;
      ctrl_latch <= 1'b0;
      ctrl_clk   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (vblank_start) begin
            state      <= ST_LATCH;
            phase      <= PHASE_LOAD;
            ctrl_latch <= 1'b1;
          end
        end

        ST_LATCH: begin
          if (phase_done) begin
            state      <= ST_LOW;
            phase      <= PHASE_LOAD;
            ctrl_latch <= 1'b0;
            ctrl_clk   <= 1'b0;
          end else begin
            phase <= phase - PW'(1);
          end
        end

        ST_LOW: begin
          if (phase_done) begin
            // Data is inverted on capture so that a stored 1 means pressed;
            // the first bit (A) ends up at bit 7 after eight shifts.
            shift_1  <= {shift_1[6:0], ~ctrl_data_1};
            shift_2  <= {shift_2[6:0], ~ctrl_data_2};
            state    <= ST_HIGH;
            phase    <= PHASE_LOAD;
            ctrl_clk <= 1'b1;
          end else begin
            phase <= phase - PW'(1);
          end
        end

        ST_HIGH: begin
          if (phase_done) begin
            ctrl_clk <= 1'b0;
            bit_cnt  <= bit_cnt + 3'd1;
            phase    <= PHASE_LOAD;
            if (bit_cnt == 3'd7) begin
              state <= ST_COMMIT;
            end else begin
              state <= ST_LOW;
            end
          end else begin
            phase <= phase - PW'(1);
          end
        end

        ST_COMMIT: begin
          // Both bytes update on the same edge so the CPU never sees a
          // half-shifted or mismatched pair.
          buttons_1 <= shift_1;
          buttons_2 <= shift_2;
          state     <= ST_IDLE;
        end

        default: begin
          state      <= ST_IDLE;
          ctrl_latch <= 1'b0;
          ctrl_clk   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_responder_m.sv
// io_responder_m: CPU I/O window responder for 0x7000-0x7003.
//   0x7000 in_vblank      : read {7'b0, vblank}
//   0x7001 clr_vblank_irq : read {7'b0, vblank_irq}; any access clears the IRQ
//   0x7002 controller_1   : read committed button byte of controller 1
//   0x7003 controller_2   : read committed button byte of controller 2
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   cpu_access, cpu_rwb          : bus cycle strobe, 1 = read / 0 = write
//   SELECT_*                     : one-hot decoded selects from the decoder
//   cpu_data_out, cpu_data_oe    : combinational read data and bus enable
//   vblank, vblank_start         : video timing level and frame-start pulse
//   vblank_irq                   : vblank interrupt latch output
//   ctrl_latch, ctrl_clk         : shared controller latch / shift clock
//   ctrl_data_1, ctrl_data_2     : controller serial data, active-low
module io_responder_m
  import io_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_access,
  input  logic       cpu_rwb,
  input  logic       SELECT_in_vblank,
  input  logic       SELECT_clr_vblank_irq,
  input  logic       SELECT_controller_1,
  input  logic       SELECT_controller_2,
  output logic [7:0] cpu_data_out,
  output logic       cpu_data_oe,
  input  logic       vblank,
  input  logic       vblank_start,
  output logic       vblank_irq,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  input  logic       ctrl_data_1,
  input  logic       ctrl_data_2
);

  logic [7:0] buttons_1;
  logic [7:0] buttons_2;
  logic       any_select;

  controller_poller_m #(
    .CLK_DIV (CLK_DIV)
  ) u_poller (
    .clk          (clk),
    .rst          (rst),
    .vblank_start (vblank_start),
    .ctrl_data_1  (ctrl_data_1),
    .ctrl_data_2  (ctrl_data_2),
    .ctrl_latch   (ctrl_latch),
    .ctrl_clk     (ctrl_clk),
    .buttons_1    (buttons_1),
    .buttons_2    (buttons_2)
  );

  // Set has priority over a same-cycle clear so a new frame's IRQ is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblank_irq <= 1'b0;
    end else if (vblank_start) begin
      vblank_irq <= 1'b1;
    end else if (cpu_access && SELECT_clr_vblank_irq) begin
      vblank_irq <= 1'b0;
    end
  end

  assign any_select = SELECT_in_vblank | SELECT_clr_vblank_irq |
                      SELECT_controller_1 | SELECT_controller_2;

  always_comb begin
    cpu_data_oe  = cpu_rwb & any_select;
    cpu_data_out = '0;
    if (cpu_rwb) begin
      if (SELECT_in_vblank) begin
        cpu_data_out = flag_byte(vblank);
      end else if (SELECT_clr_vblank_irq) begin
        cpu_data_out = flag_byte(vblank_irq);
      end else if (SELECT_controller_1) begin
        cpu_data_out = buttons_1;
      end else if (SELECT_controller_2) begin
        cpu_data_out = buttons_2;
      end
    end
  end

endmodule

// File: tb/tb_io_responder_m.sv
module tb_io_responder_m;

  logic       clk = 1'b0;
  logic       rst;
  // primary DUT (CLK_DIV = 8)
  logic       cpu_access, cpu_rwb;
  logic       sel_vb, sel_clr, sel_c1, sel_c2;
  logic [7:0] dout;
  logic       doe, vblank, vblank_start, irq, latch, cclk, d1, d2;
  // second DUT (CLK_DIV = 1)
  logic       b_access, b_rwb, b_sel_c1, b_sel_c2, b_vblank_start;
  logic [7:0] dout1;
  logic       doe1, irq1, latch1, cclk1, b_d1, b_d2;

  always #5 clk = ~clk;

  io_responder_m dut (
    .clk(clk), .rst(rst), .cpu_access(cpu_access), .cpu_rwb(cpu_rwb),
    .SELECT_in_vblank(sel_vb), .SELECT_clr_vblank_irq(sel_clr),
    .SELECT_controller_1(sel_c1), .SELECT_controller_2(sel_c2),
    .cpu_data_out(dout), .cpu_data_oe(doe), .vblank(vblank),
    .vblank_start(vblank_start), .vblank_irq(irq), .ctrl_latch(latch),
    .ctrl_clk(cclk), .ctrl_data_1(d1), .ctrl_data_2(d2)
  );

  io_responder_m #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .cpu_access(b_access), .cpu_rwb(b_rwb),
    .SELECT_in_vblank(1'b0), .SELECT_clr_vblank_irq(1'b0),
    .SELECT_controller_1(b_sel_c1), .SELECT_controller_2(b_sel_c2),
    .cpu_data_out(dout1), .cpu_data_oe(doe1), .vblank(1'b0),
    .vblank_start(b_vblank_start), .vblank_irq(irq1), .ctrl_latch(latch1),
    .ctrl_clk(cclk1), .ctrl_data_1(b_d1), .ctrl_data_2(b_d2)
  );

  // Controller models: parallel load while latch is high, shift on the
  // rising edge of the shift clock, serial output active-low, A first.
  logic [7:0] btn1, btn2, sh1 = '0, sh2 = '0;
  logic [7:0] b_btn1, b_btn2, b_sh1 = '0, b_sh2 = '0;
  logic       prev_cclk = 1'b0, b_prev_cclk = 1'b0;

  always @(posedge clk) begin
    prev_cclk <= cclk;
    if (latch) begin
      sh1 <= btn1;
      sh2 <= btn2;
    end else if (cclk && !prev_cclk) begin
      sh1 <= {sh1[6:0], 1'b0};
      sh2 <= {sh2[6:0], 1'b0};
    end
  end

  always @(posedge clk) begin
    b_prev_cclk <= cclk1;
    if (latch1) begin
      b_sh1 <= b_btn1;
      b_sh2 <= b_btn2;
    end else if (cclk1 && !b_prev_cclk) begin
      b_sh1 <= {b_sh1[6:0], 1'b0};
      b_sh2 <= {b_sh2[6:0], 1'b0};
    end
  end

  assign d1   = ~sh1[7];
  assign d2   = ~sh2[7];
  assign b_d1 = ~b_sh1[7];
  assign b_d2 = ~b_sh2[7];

  // Scoreboard
  typedef enum {S_IRQ, S_DOUT, S_DOE, S_LATCH, S_CCLK, S_LATCH1, S_CCLK1, S_DOUT1} sig_t;
  typedef struct {
    sig_t       sig;
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] observe(input sig_t s);
    case (s)
      S_IRQ:    return {7'b0, irq};
      S_DOUT:   return dout;
      S_DOE:    return {7'b0, doe};
      S_LATCH:  return {7'b0, latch};
      S_CCLK:   return {7'b0, cclk};
      S_LATCH1: return {7'b0, latch1};
      S_CCLK1:  return {7'b0, cclk1};
      default:  return dout1;
    endcase
  endfunction

  task automatic push(input sig_t s, input string tag, input logic [7:0] exp);
    exp_t e;
    e.sig = s;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sig), e.exp);
    end
  endtask

  // Expected latch/clock waveform k cycles after vblank_start, derived from
  // the documented timing: latch on 1..d, then 16 phases of d cycles, LOW first.
  task automatic push_wave(input int k, input int d, input bit second);
    logic el, ec;
    el = (k >= 1 && k <= d);
    ec = (k > d && k <= 17 * d) ? (((k - d - 1) / d) % 2 == 1) : 1'b0;
    if (second) begin
      push(S_LATCH1, $sformatf("latch1@%0d", k), {7'b0, el});
      push(S_CCLK1,  $sformatf("cclk1@%0d", k),  {7'b0, ec});
    end else begin
      push(S_LATCH, $sformatf("latch@%0d", k), {7'b0, el});
      push(S_CCLK,  $sformatf("cclk@%0d", k),  {7'b0, ec});
    end
  endtask

  task automatic idle_inputs();
    cpu_access = 1'b0; cpu_rwb = 1'b1;
    sel_vb = 1'b0; sel_clr = 1'b0; sel_c1 = 1'b0; sel_c2 = 1'b0;
    vblank_start = 1'b0;
    b_access = 1'b0; b_rwb = 1'b1; b_sel_c1 = 1'b0; b_sel_c2 = 1'b0;
    b_vblank_start = 1'b0;
  endtask

  // Inputs are driven 1 time unit after posedge; outputs sampled at negedge.
  task automatic step();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic read_sel(input int sel);
    cpu_access = 1'b1;
    cpu_rwb    = 1'b1;
    case (sel)
      0:       sel_vb  = 1'b1;
      1:       sel_clr = 1'b1;
      2:       sel_c1  = 1'b1;
      default: sel_c2  = 1'b1;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1; vblank = 1'b0;
    btn1 = 8'h00; btn2 = 8'h00; b_btn1 = 8'h00; b_btn2 = 8'h00;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    step();

    // Reset state
    push(S_IRQ, "rst_irq", 8'h00);
    push(S_LATCH, "rst_latch", 8'h00);
    push(S_CCLK, "rst_cclk", 8'h00);
    push(S_DOE, "rst_doe_idle", 8'h00);
    push(S_DOUT, "rst_dout_idle", 8'h00);
    push(S_LATCH1, "rst_latch1", 8'h00);
    step();
    read_sel(2); push(S_DOUT, "rst_c1", 8'h00); push(S_DOE, "rst_c1_oe", 8'h01);
    step(); idle_inputs();
    read_sel(3); push(S_DOUT, "rst_c2", 8'h00);
    step(); idle_inputs();

    // Poll 1: CLK_DIV=8, A+Right on pad 1, Start on pad 2, with IRQ and retrigger
    btn1 = 8'h81; btn2 = 8'h10;
    for (int k = 0; k <= 156; k++) begin
      idle_inputs();
      if (k == 0)  vblank_start = 1'b1;
      if (k >= 1)  push_wave(k, 8, 1'b0);
      if (k == 1)  push(S_IRQ, "irq_set", 8'h01);
      if (k == 2)  begin read_sel(1); push(S_DOUT, "irq_read", 8'h01); push(S_DOE, "irq_read_oe", 8'h01); end
      if (k == 3)  push(S_IRQ, "irq_cleared", 8'h00);
      if (k == 50) vblank_start = 1'b1;
      if (k == 51) push(S_IRQ, "irq_retrig", 8'h01);
      if (k == 60) begin vblank_start = 1'b1; read_sel(1); end
      if (k == 61) push(S_IRQ, "irq_set_wins", 8'h01);
      if (k == 62) begin
        cpu_access = 1'b1; cpu_rwb = 1'b0; sel_clr = 1'b1;
        push(S_DOE, "irq_wr_oe", 8'h00); push(S_DOUT, "irq_wr_dout", 8'h00);
      end
      if (k == 63)  push(S_IRQ, "irq_wr_cleared", 8'h00);
      if (k == 136) begin read_sel(3); push(S_DOUT, "c2_old@136", 8'h00); end
      if (k == 137) begin read_sel(2); push(S_DOUT, "c1_old@137", 8'h00); end
      if (k == 138) begin read_sel(2); push(S_DOUT, "c1_new@138", 8'h81); end
      if (k == 139) begin read_sel(3); push(S_DOUT, "c2_new@139", 8'h10); end
      if (k == 145) begin
        cpu_access = 1'b1; cpu_rwb = 1'b0; sel_c1 = 1'b1;
        push(S_DOE, "wr_c1_oe", 8'h00); push(S_DOUT, "wr_c1_dout", 8'h00);
      end
      if (k == 146) begin read_sel(2); push(S_DOUT, "c1_after_wr", 8'h81); end
      step();
    end

    // Bus: in_vblank read
    idle_inputs(); vblank = 1'b1; read_sel(0);
    push(S_DOUT, "vblank_rd", 8'h01); push(S_DOE, "vblank_rd_oe", 8'h01);
    step(); idle_inputs(); vblank = 1'b0; read_sel(0);
    push(S_DOUT, "novblank_rd", 8'h00);
    step(); idle_inputs();

    // Poll 2 with reset during the HIGH phase of bit 3 (cycles 65..72)
    btn1 = 8'h5A; btn2 = 8'hA5;
    for (int k = 0; k <= 65; k++) begin
      idle_inputs();
      if (k == 0) vblank_start = 1'b1;
      if (k >= 1) push_wave(k, 8, 1'b0);
      step();
    end
    idle_inputs(); rst = 1'b1; step();
    step();
    rst = 1'b0;
    push(S_IRQ, "midrst_irq", 8'h00);
    push(S_LATCH, "midrst_latch", 8'h00);
    push(S_CCLK, "midrst_cclk", 8'h00);
    read_sel(2); push(S_DOUT, "midrst_c1", 8'h00);
    step(); idle_inputs();
    read_sel(3); push(S_DOUT, "midrst_c2", 8'h00);
    step(); idle_inputs();
    for (int k = 0; k < 20; k++) begin
      push(S_LATCH, $sformatf("midrst_idle_latch%0d", k), 8'h00);
      push(S_CCLK,  $sformatf("midrst_idle_cclk%0d", k),  8'h00);
      step();
    end

    // Poll 3: clean poll after reset
    for (int k = 0; k <= 140; k++) begin
      idle_inputs();
      if (k == 0)   vblank_start = 1'b1;
      if (k >= 1)   push_wave(k, 8, 1'b0);
      if (k == 137) begin read_sel(2); push(S_DOUT, "p3_c1_old", 8'h00); end
      if (k == 138) begin read_sel(2); push(S_DOUT, "p3_c1_new", 8'h5A); end
      if (k == 139) begin read_sel(3); push(S_DOUT, "p3_c2_new", 8'hA5); end
      step();
    end

    // CLK_DIV=1 instance: all buttons pressed on pad 1, 0x3C on pad 2
    b_btn1 = 8'hFF; b_btn2 = 8'h3C;
    for (int k = 0; k <= 22; k++) begin
      idle_inputs();
      if (k == 0)  b_vblank_start = 1'b1;
      if (k >= 1)  push_wave(k, 1, 1'b1);
      if (k == 18) begin b_rwb = 1'b1; b_sel_c1 = 1'b1; push(S_DOUT1, "d1_c1_commit", 8'h00); end
      if (k == 19) begin b_rwb = 1'b1; b_sel_c1 = 1'b1; push(S_DOUT1, "d1_c1_new", 8'hFF); end
      if (k == 20) begin b_rwb = 1'b1; b_sel_c2 = 1'b1; push(S_DOUT1, "d1_c2_new", 8'h3C); end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
